irq_pending_ctrl: RTL

//  Interrupt front-end sitting directly upstream of the MIPS core's interrupts[7:0] input.
//  - Synchronises raw, asynchronous board/testbench interrupt lines.
//  - Per line, either captures rising edges into sticky pending bits or passes the level through.
//  - Applies a mask and drives the core.
//  - Mask, mode and clear registers are memory-mapped on the core's store bus (memwrite/dataadr/writedata).

---
 rtl/irq_pending_ctrl_pkg.sv | 11 +
 rtl/irq_pending_ctrl_sync.sv | 15 +
 rtl/irq_pending_ctrl.sv | 47 ++++
 3 files changed

// File: rtl/irq_pending_ctrl_pkg.sv
// irq_pending_ctrl_pkg: register map, defaults and address-decode helper for the interrupt front-end
package irq_pending_ctrl_pkg;
   localparam int IRQ_NIRQ = 8;
   localparam logic [31:0] IRQ_BASE_ADDR = 32'hFFFF_FF00;
   localparam logic [31:0] IRQ_MASK_OFF = 32'd0;
   localparam logic [31:0] IRQ_MODE_OFF = 32'd4;
   localparam logic [31:0] IRQ_CLR_OFF = 32'd8;
   function automatic logic reg_hit(input logic we, input logic [31:0] adr, input logic [31:0] base, input logic [31:0] off);
      return we && adr == base + off;
   endfunction
endpackage

// File: rtl/irq_pending_ctrl_sync.sv
// irq_pending_ctrl_sync: multi-stage single-bit synchroniser with async active-low reset
module irq_pending_ctrl_sync #(
   parameter int STAGES = 2
) (
   input  logic ph1,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] chain;
   always_ff @(posedge ph1 or negedge reset)
      if (!reset) chain <= '0;
      else chain <= {chain[STAGES-2:0], d};
   assign q = chain[STAGES-1];
endmodule

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: synchronised, maskable edge/level interrupt front-end with memory-mapped control
module irq_pending_ctrl
   import irq_pending_ctrl_pkg::*;
#(
   parameter int NIRQ = IRQ_NIRQ,
   parameter int SYNC_STAGES = 2,
   parameter logic [31:0] BASE_ADDR = IRQ_BASE_ADDR
) (
   input  logic            ph1,
   input  logic            reset,
   input  logic [NIRQ-1:0] irq_raw,
   input  logic            memwrite,
   input  logic [31:0]     dataadr,
   input  logic [31:0]     writedata,
   output logic [NIRQ-1:0] interrupts,
   output logic            irq_any,
   output logic [NIRQ-1:0] pending
);
   logic [NIRQ-1:0] s, prev, mask, mode, pend, clr, rise, wd;
   logic mask_we, mode_we, clr_we, unused_wd;
   for (genvar i = 0; i < NIRQ; i++) begin : g_sync
      irq_pending_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync (.ph1(ph1), .reset(reset), .d(irq_raw[i]), .q(s[i]));
   end
   assign wd = writedata[NIRQ-1:0];
   assign unused_wd = ^writedata;
   assign mask_we = reg_hit(memwrite, dataadr, BASE_ADDR, IRQ_MASK_OFF);
   assign mode_we = reg_hit(memwrite, dataadr, BASE_ADDR, IRQ_MODE_OFF);
   assign clr_we = reg_hit(memwrite, dataadr, BASE_ADDR, IRQ_CLR_OFF);
   assign clr = clr_we ? wd : '0;
   assign rise = s & ~prev;
   // Set is OR-ed after the clear so a same-cycle rise survives a CLR write
   always_ff @(posedge ph1 or negedge reset)
      if (!reset) begin
         mask <= '0;
         mode <= '1;
         prev <= '0;
         pend <= '0;
      end else begin
         if (mask_we) mask <= wd;
         if (mode_we) mode <= wd;
         prev <= s;
         pend <= (mode & ((pend & ~clr) | rise)) | (~mode & s);
      end
   assign pending = pend;
   assign interrupts = pend & mask;
   assign irq_any = |interrupts;
endmodule
